// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin scanning multiplexer: mode encodings
// and the round-robin search helper.
`default_nettype none

package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam int   MAX_CH      = 64;

  // Returns {found, index} of the first set bit of req, starting at ptr and
  // wrapping at nch. ptr must be below nch, so a single subtraction wraps it.
  function automatic logic [6:0] rr_next(input logic [5:0]  ptr,
                                         input logic [63:0] req,
                                         input int unsigned nch);
    logic [6:0]  res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      k = 32'(ptr) + i;
      if (k >= nch) k = k - nch;
      if ((i < nch) && !res[6] && req[k[5:0]]) res = {1'b1, k[5:0]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_arb.sv
// Combinational round-robin priority search over NCH requests starting at ptr.
`default_nettype none

module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  logic [6:0] res;

  always_comb begin
    res = rr_next(6'(ptr), 64'(req), NCH);
  end

  assign gnt_vld = res[6];
  assign gnt_idx = SELW'(res[5:0]);

endmodule

`default_nettype wire

// File: rtl/mux_rr_scan.sv
// NCH-channel registered multiplexer with valid/ready output, selectable
// between direct channel selection and a round-robin scan of active channels.
`default_nettype none

module mux_rr_scan
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ack,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  logic [WIDTH-1:0] ch_data [NCH];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_nxt;
  logic             arb_vld;
  logic [SELW-1:0]  arb_idx;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic             free;
  logic             capture;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  mux_rr_arb #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    sel_ok  = (32'(sel) < NCH);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode == MODE_SCAN) begin
      gnt_vld = arb_vld;
      gnt_idx = arb_idx;
    end else begin
      gnt_vld = sel_ok && in_valid[sel];
      gnt_idx = sel;
    end
    free    = !out_valid || out_ready;
    capture = free && gnt_vld;
    ptr_nxt = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    // Gated by rst so the acknowledge also drops immediately on async reset.
    in_ack  = (capture && !rst) ? (NCH'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (free) out_valid <= gnt_vld;
      if (capture) begin
        out_data <= ch_data[gnt_idx];
        out_ch   <= gnt_idx;
      end
      // Only scan-mode captures advance the pointer.
      if (capture && (mode == MODE_SCAN)) ptr <= ptr_nxt;
      if ((mode == MODE_DIRECT) && !sel_ok) sel_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_scan.sv
// Directed self-checking bench for mux_rr_scan with WIDTH=8, NCH=5.
`default_nettype none

module tb_mux_rr_scan;

  localparam int WIDTH = 8;
  localparam int NCH   = 5;
  localparam int SELW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ack;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;

  int vectors = 0;
  int miscompares = 0;

  mux_rr_scan #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = base + 8'(k);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 5'b11111; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
    set_data(8'h40);
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++;
    if (out_data !== 8'h00 || out_ch !== 3'd0) begin miscompares++; $display("FAIL reset_data got=%h/%0d exp=00/0", out_data, out_ch); end
    vectors++;
    if (in_ack !== 5'b0 || sel_err !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b/%b exp=00000/0", in_ack, sel_err); end
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
  endtask

  task automatic test_direct();
    @(negedge clk);
    mode = 1'b0; sel = 3'd3; in_valid = 5'b01000; out_ready = 1'b1;
    in_data = '0; in_data[3*WIDTH +: WIDTH] = 8'hA5;
    #1;
    vectors++;
    if (in_ack !== 5'b01000) begin miscompares++; $display("FAIL direct_ack got=%b exp=01000", in_ack); end
    @(posedge clk); #1;
    vectors++;
    if (out_data !== 8'hA5 || out_ch !== 3'd3 || out_valid !== 1'b1)
      begin miscompares++; $display("FAIL direct_out got=%h/%0d/%b exp=a5/3/1", out_data, out_ch, out_valid); end
    @(negedge clk);
    in_valid = '0;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL direct_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_scan_wrap();
    logic [SELW-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp = SELW'(i % NCH);
      @(negedge clk);
      mode = 1'b1; in_valid = 5'b11111; set_data(8'h10);
      #1;
      vectors++;
      if (in_ack !== (5'b00001 << exp)) begin miscompares++; $display("FAIL scan_ack[%0d] got=%b exp_ch=%0d", i, in_ack, exp); end
      @(posedge clk); #1;
      vectors++;
      if (out_ch !== exp || out_data !== (8'h10 + 8'(exp)) || out_valid !== 1'b1)
        begin miscompares++; $display("FAIL scan_out[%0d] got=%0d/%h exp=%0d/%h", i, out_ch, out_data, exp, 8'h10 + 8'(exp)); end
    end
  endtask

  task automatic test_scan_skip();
    logic [4:0] exp_ack [5];
    logic [4:0] vin [5];
    // ptr=1 on entry: ch1, then ptr=2 so {0,1} grants ch0 then ch1, then idle, then ch2.
    vin     = '{5'b00010, 5'b00011, 5'b00011, 5'b00000, 5'b11111};
    exp_ack = '{5'b00010, 5'b00001, 5'b00010, 5'b00000, 5'b00100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = vin[i];
      #1;
      vectors++;
      if (in_ack !== exp_ack[i]) begin miscompares++; $display("FAIL skip_ack[%0d] got=%b exp=%b", i, in_ack, exp_ack[i]); end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== (exp_ack[i] != 5'b0)) begin miscompares++; $display("FAIL skip_valid[%0d] got=%b exp=%b", i, out_valid, exp_ack[i] != 5'b0); end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 5'b00010; out_ready = 1'b1; set_data(8'h10);
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 3'd1 || out_data !== 8'h11) begin miscompares++; $display("FAIL stall_load got=%0d/%h exp=1/11", out_ch, out_data); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 5'b11111; set_data(8'h20 + 8'(i));
      mode = i[0]; sel = 3'(i);
      #1;
      vectors++;
      if (in_ack !== 5'b0) begin miscompares++; $display("FAIL stall_ack[%0d] got=%b exp=00000", i, in_ack); end
      @(posedge clk); #1;
      vectors++;
      if (out_ch !== 3'd1 || out_data !== 8'h11 || out_valid !== 1'b1)
        begin miscompares++; $display("FAIL stall_hold[%0d] got=%0d/%h/%b exp=1/11/1", i, out_ch, out_data, out_valid); end
    end
    @(negedge clk);
    mode = 1'b1; out_ready = 1'b1; set_data(8'h30);
    #1;
    vectors++;
    if (in_ack !== 5'b00100) begin miscompares++; $display("FAIL stall_release_ack got=%b exp=00100", in_ack); end
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 3'd2 || out_data !== 8'h32) begin miscompares++; $display("FAIL stall_release got=%0d/%h exp=2/32", out_ch, out_data); end
  endtask

  task automatic test_sel_err();
    vectors++;
    if (sel_err !== 1'b0) begin miscompares++; $display("FAIL sel_err_pre got=%b exp=0", sel_err); end
    @(negedge clk);
    mode = 1'b0; sel = 3'd6; in_valid = 5'b11111; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ack !== 5'b0) begin miscompares++; $display("FAIL sel_err_ack got=%b exp=00000", in_ack); end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || sel_err !== 1'b1) begin miscompares++; $display("FAIL sel_err_set got=%b/%b exp=0/1", out_valid, sel_err); end
    @(negedge clk);
    sel = 3'd2;
    #1;
    vectors++;
    if (in_ack !== 5'b00100) begin miscompares++; $display("FAIL sel_ok_ack got=%b exp=00100", in_ack); end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_ch !== 3'd2 || sel_err !== 1'b1)
      begin miscompares++; $display("FAIL sel_err_sticky got=%b/%0d/%b exp=1/2/1", out_valid, out_ch, sel_err); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 1'b1; in_valid = 5'b11111; out_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0 || in_ack !== 5'b0 || sel_err !== 1'b0)
      begin miscompares++; $display("FAIL reset_async got=%b/%h/%0d/%b/%b exp=0/00/0/00000/0", out_valid, out_data, out_ch, in_ack, sel_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ack !== 5'b00001) begin miscompares++; $display("FAIL restart_ack got=%b exp=00001", in_ack); end
    @(posedge clk); #1;
    vectors++;
    if (out_ch !== 3'd0 || out_data !== 8'h30 || out_valid !== 1'b1)
      begin miscompares++; $display("FAIL restart_out got=%0d/%h/%b exp=0/30/1", out_ch, out_data, out_valid); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_scan_skip();
    test_stall();
    test_sel_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
